// File: rtl/imm_gen_stage.sv
// Immediate generator for the decode path with a small result FIFO.
// Classifies the format, sign-extends the immediate and adds PC for targets.
module imm_gen_stage #(
  parameter int Width        = 32,
  parameter int Depth        = 2,
  parameter bit ScaleOffsets = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [Width-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [Width-1:0] out_pc,
  output logic [Width-1:0] out_target
);

  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);
  localparam logic [CW-1:0] Full = CW'(Depth);

  typedef struct packed {
    logic [Width-1:0] imm;
    logic [2:0]       fmt;
    logic             ill;
    logic [Width-1:0] pc;
    logic [Width-1:0] tgt;
  } ent_t;

  logic [6:0] op;
  logic       is_i;
  logic       is_s;
  logic       is_b;
  logic       is_u;
  logic       is_j;
  logic       is_r;

  assign op   = in_instr[6:0];
  assign is_i = (op == 7'b0000011) || (op == 7'b0010011) ||
                (op == 7'b1100111) || (op == 7'b1110011);
  assign is_s = (op == 7'b0100011);
  assign is_b = (op == 7'b1100011);
  assign is_u = (op == 7'b0110111) || (op == 7'b0010111);
  assign is_j = (op == 7'b1101111);
  assign is_r = (op == 7'b0110011);

  logic [Width-1:0] imm_c;
  logic [Width-1:0] off_c;
  logic [2:0]       fmt_c;
  logic             ill_c;

  // Format decode and sign-extended immediate / byte offset
  always_comb begin
    imm_c = '0;
    fmt_c = 3'd0;
    ill_c = 1'b0;
    unique case (1'b1)
      is_i: begin
        imm_c = Width'($signed(in_instr[31:20]));
        fmt_c = 3'd1;
      end
      is_s: begin
        imm_c = Width'($signed({in_instr[31:25], in_instr[11:7]}));
        fmt_c = 3'd2;
      end
      is_b: begin
        fmt_c = 3'd3;
        if (ScaleOffsets)
          imm_c = Width'($signed({in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0}));
        else
          imm_c = Width'($signed({in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8]}));
      end
      is_u: begin
        imm_c = Width'($signed({in_instr[31:12], 12'b0}));
        fmt_c = 3'd4;
      end
      is_j: begin
        fmt_c = 3'd5;
        if (ScaleOffsets)
          imm_c = Width'($signed({in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0}));
        else
          imm_c = Width'($signed({in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21]}));
      end
      is_r: fmt_c = 3'd0;
      default: ill_c = 1'b1;
    endcase
    off_c = imm_c;
    if (!ScaleOffsets && (is_b || is_j))
      off_c = imm_c << 1;
  end

  ent_t          ent_in;
  ent_t          head;
  ent_t          mem [Depth];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign ent_in.imm = imm_c;
  assign ent_in.fmt = fmt_c;
  assign ent_in.ill = ill_c;
  assign ent_in.pc  = in_pc;
  assign ent_in.tgt = in_pc + off_c;

  assign in_ready  = !rst && (count < Full);
  assign out_valid = !rst && (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // FIFO storage, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= ent_in;
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head        = mem[rd_ptr];
  assign out_imm     = out_valid ? head.imm : '0;
  assign out_fmt     = out_valid ? head.fmt : 3'd0;
  assign out_illegal = out_valid ? head.ill : 1'b0;
  assign out_pc      = out_valid ? head.pc  : '0;
  assign out_target  = out_valid ? head.tgt : '0;

endmodule
